alu_mcycle: RTL

//  Parametrised multicycle ALU for the multiciclo datapath: single-cycle logic/arith ops plus

---
 rtl/alu_mcycle.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_mcycle.sv
// alu_mcycle: multicycle ALU with single-cycle logic/arith ops and iterative MULTU/DIVU.
// Simple ops finish on the accept edge, and iterative ops produce one bit per edge for N edges.
module alu_mcycle #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] A_i,
    input  logic [N-1:0] B_i,
    input  logic         c_i,
    input  logic [3:0]   ope_i,
    input  logic         branch_i,
    input  logic [2:0]   brctrl_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] sal_o,
    output logic [N-1:0] hi_o,
    output logic         c_o,
    output logic         ovf_o,
    output logic         zero_o,
    output logic         dz_o,
    output logic         brflag_o
);
    localparam int CW = $clog2(N + 1);
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111, OP_NOR = 4'b1100, OP_MUL = 4'b1000, OP_DIV = 4'b1010;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sal_q, sal_d, hi_q, hi_d, lw_q, lw_d, hw_q, hw_d, b_q, b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           c_q, c_d, ovf_q, ovf_d, zero_q, zero_d, dz_q, dz_d;
    logic           brflag_q, brflag_d, bren_q, bren_d, done_q, done_d;
    logic [2:0]     brc_q, brc_d;

    logic [N:0]     add_s, sub_s, mul_s, div_r;
    logic [N-1:0]   div_n, step_hi, step_lo, res, rhi;
    logic           add_ov, sub_ov, div_ge, rc, rov, rdz, iter;

    function automatic logic cond(input logic [2:0] bc, input logic [N-1:0] r);
        logic z, m;
        z = (r == '0);
        m = r[N-1];
        return bc == 3'd0 ? z : bc == 3'd1 ? !z : bc == 3'd2 ? m : bc == 3'd3 ? !m :
               bc == 3'd4 ? (m | z) : bc == 3'd5 ? (!m & !z) : 1'b0;
    endfunction

    assign add_s  = {1'b0, A_i} + {1'b0, B_i} + {{N{1'b0}}, c_i};
    assign sub_s  = {1'b0, A_i} + {1'b0, ~B_i} + {{N{1'b0}}, 1'b1};
    assign add_ov = (A_i[N-1] == B_i[N-1]) && (add_s[N-1] != A_i[N-1]);
    assign sub_ov = (A_i[N-1] != B_i[N-1]) && (sub_s[N-1] != A_i[N-1]);
    assign iter   = (ope_i == OP_MUL) || (ope_i == OP_DIV && B_i != '0);

    // Multiply shifts {hw,lw} right after a conditional add; divide shifts the dividend left into hw.
    assign mul_s   = {1'b0, hw_q} + (lw_q[0] ? {1'b0, b_q} : '0);
    assign div_r   = {hw_q, lw_q[N-1]};
    assign div_ge  = div_r >= {1'b0, b_q};
    assign div_n   = div_ge ? div_r[N-1:0] - b_q : div_r[N-1:0];
    assign step_hi = state_q == MUL ? mul_s[N:1] : div_n;
    assign step_lo = state_q == MUL ? {mul_s[0], lw_q[N-1:1]} : {lw_q[N-2:0], div_ge};

    always_comb begin
        res = '0;
        rhi = hi_q;
        rc  = 1'b0;
        rov = 1'b0;
        rdz = 1'b0;
        case (ope_i)
            OP_AND: res = A_i & B_i;
            OP_OR:  res = A_i | B_i;
            OP_NOR: res = ~(A_i | B_i);
            OP_ADD: begin res = add_s[N-1:0]; rc = add_s[N]; rov = add_ov; end
            OP_SUB: begin res = sub_s[N-1:0]; rc = sub_s[N]; rov = sub_ov; end
            OP_SLT: res = {{(N-1){1'b0}}, sub_s[N-1] ^ sub_ov};
            OP_DIV: begin res = '1; rhi = A_i; rdz = 1'b1; end
            default: res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sal_d    = sal_q;
        hi_d     = hi_q;
        lw_d     = lw_q;
        hw_d     = hw_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        dz_d     = dz_q;
        brflag_d = brflag_q;
        bren_d   = bren_q;
        brc_d    = brc_q;
        done_d   = 1'b0;
        if (state_q == IDLE && start_i) begin
            bren_d = branch_i;
            brc_d  = brctrl_i;
            c_d    = 1'b0;
            ovf_d  = 1'b0;
            dz_d   = 1'b0;
            if (iter) begin
                lw_d    = A_i;
                hw_d    = '0;
                b_d     = B_i;
                cnt_d   = CW'(N);
                state_d = ope_i == OP_MUL ? MUL : DIV;
            end else begin
                sal_d    = res;
                hi_d     = rhi;
                c_d      = rc;
                ovf_d    = rov;
                dz_d     = rdz;
                zero_d   = res == '0;
                brflag_d = branch_i & cond(brctrl_i, res);
                done_d   = 1'b1;
            end
        end else if (state_q != IDLE) begin
            hw_d  = step_hi;
            lw_d  = step_lo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                sal_d    = step_lo;
                hi_d     = step_hi;
                zero_d   = step_lo == '0;
                brflag_d = bren_q & cond(brc_q, step_lo);
                done_d   = 1'b1;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sal_q    <= '0;
            hi_q     <= '0;
            lw_q     <= '0;
            hw_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            dz_q     <= 1'b0;
            brflag_q <= 1'b0;
            bren_q   <= 1'b0;
            brc_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sal_q    <= sal_d;
            hi_q     <= hi_d;
            lw_q     <= lw_d;
            hw_q     <= hw_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            dz_q     <= dz_d;
            brflag_q <= brflag_d;
            bren_q   <= bren_d;
            brc_q    <= brc_d;
            done_q   <= done_d;
        end
    end

    assign busy_o   = state_q != IDLE;
    assign done_o   = done_q;
    assign sal_o    = sal_q;
    assign hi_o     = hi_q;
    assign c_o      = c_q;
    assign ovf_o    = ovf_q;
    assign zero_o   = zero_q;
    assign dz_o     = dz_q;
    assign brflag_o = brflag_q;
endmodule
